sram_req_ctrl: RTL and testbench

SRAM_REQ_CTRL -- requirements
Module: sram_req_ctrl

---
 rtl/sram_req_ctrl.sv | 142 ++++++++++++++
 tb/tb_sram_req_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: issues single-port SRAM requests one per cycle and returns
// read data in order through a credit-limited first-word-fall-through FIFO.
// A read issued in cycle T has its data registered by the wrapper in T+2;
// credits count reads in flight plus FIFO entries so a push never overflows.
module sram_req_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int RESP_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_wmode,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic [ADDR_W-1:0]             RW0_addr,
  output logic                          RW0_en,
  output logic                          RW0_wmode,
  output logic [DATA_W-1:0]             RW0_wdata,
  input  logic [DATA_W-1:0]             RW0_rdata,
  output logic [$clog2(RESP_DEPTH):0]   credits_used
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RESP_DEPTH);

  logic              accept;
  logic              rd_accept;
  logic              push;
  logic              pop;

  logic              issue_en_q,    issue_en_d;
  logic              issue_wmode_q, issue_wmode_d;
  logic [ADDR_W-1:0] issue_addr_q,  issue_addr_d;

  logic [1:0]        rd_sr_q, rd_sr_d;

  logic [DATA_W-1:0] fifo_mem_q [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [CNT_W-1:0]  credits_q, credits_d;

  // Handshake decode; ready depends only on reset and outstanding credits.
  always_comb begin
    req_ready  = !rst && (credits_q < DEPTH_C);
    accept     = req_valid && req_ready;
    rd_accept  = accept && !req_wmode;
    resp_valid = (count_q != '0);
    pop        = resp_valid && resp_ready;
    push       = rd_sr_q[1];
  end

  // Issue register next state: a non-accepting edge drops en/wmode but keeps the address.
  always_comb begin
    issue_en_d    = accept;
    issue_wmode_d = accept && req_wmode;
    issue_addr_d  = accept ? req_addr : issue_addr_q;
  end

  // Issue register feeding the SRAM wrapper.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_en_q    <= 1'b0;
      issue_wmode_q <= 1'b0;
      issue_addr_q  <= '0;
    end else begin
      issue_en_q    <= issue_en_d;
      issue_wmode_q <= issue_wmode_d;
      issue_addr_q  <= issue_addr_d;
    end
  end

  assign RW0_en    = issue_en_q;
  assign RW0_wmode = issue_wmode_q;
  assign RW0_addr  = issue_addr_q;
  // The wrapper registers write data itself, so it is taken straight from the request.
  assign RW0_wdata = req_wdata;

  // Read-valid pipeline next state, aligned with the wrapper's two-cycle read latency.
  always_comb begin
    rd_sr_d = {rd_sr_q[0], issue_en_q && !issue_wmode_q};
  end

  // Read-valid pipeline; clearing it on reset discards late returns of in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sr_q <= '0;
    end else begin
      rd_sr_q <= rd_sr_d;
    end
  end

  // FIFO pointer, occupancy and credit next state; pointers wrap at the power-of-two depth.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    credits_d = credits_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (rd_accept && !pop) begin
      credits_d = credits_q + 1'b1;
    end else if (pop && !rd_accept) begin
      credits_d = credits_q - 1'b1;
    end
  end

  // FIFO control and credit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      credits_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      credits_q <= credits_d;
    end
  end

  // FIFO storage; a push into a slot freed by a same-edge pop is safe since pointers differ.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem_q[wr_ptr_q] <= RW0_rdata;
    end
  end

  assign resp_rdata   = fifo_mem_q[rd_ptr_q];
  assign credits_used = credits_q;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed and randomized checks of sram_req_ctrl against
// a behavioural SRAM wrapper and an address->data / response-order model.
module tb_sram_req_ctrl;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;
  localparam int RESP_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wmode = 1'b0;
  logic [11:0]       req_addr = '0;
  logic [7:0]        req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [7:0]        resp_rdata;
  logic [11:0]       RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [7:0]        RW0_wdata;
  logic [7:0]        RW0_rdata;
  logic [2:0]        credits_used;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q [$];
  logic [7:0] ref_mem [int];

  // SRAM wrapper model: input data register, array, output data register.
  logic [7:0] sram_mem [4096];
  logic [7:0] wr_in_q;
  logic [7:0] dout_q;
  logic [7:0] rdata_q;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    wr_in_q <= RW0_wdata;
    if (RW0_en) begin
      if (RW0_wmode) sram_mem[RW0_addr] <= wr_in_q;
      else           dout_q <= sram_mem[RW0_addr];
    end
    rdata_q <= dout_q;
  end

  assign RW0_rdata = rdata_q;

  sram_req_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wmode(req_wmode), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata),
    .credits_used(credits_used)
  );

  function automatic logic [7:0] ref_read(input logic [11:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 8'h00;
  endfunction

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  // Model bookkeeping for the coming edge, then advance one clock.
  task automatic step();
    bit acc;
    bit pp;
    #1;
    acc = req_valid && req_ready;
    pp  = resp_valid && resp_ready;
    if (pp && exp_q.size() > 0) exp_q.delete(0);
    if (acc) begin
      if (req_wmode) ref_mem[int'(req_addr)] = req_wdata;
      else           exp_q.push_back(ref_read(req_addr));
    end
    clk_edge();
  endtask

  task automatic drain_responses(input string tag);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
      #1;
      if (resp_valid) begin
        n_cmp++;
        if (resp_rdata !== exp_q[0]) begin
          n_fail++;
          $display("FAIL %s_data: got %02h expected %02h", tag, resp_rdata, exp_q[0]);
        end
      end
      step();
    end
    resp_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || credits_used !== 3'd0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_empty: pending=%0d credits=%0d resp_valid=%b expected 0/0/0",
               tag, exp_q.size(), credits_used, resp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_edge();
    clk_edge();
    n_cmp++;
    if (RW0_en !== 1'b0 || RW0_wmode !== 1'b0 || RW0_addr !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_issue: en=%b wmode=%b addr=%03h expected 0/0/000", RW0_en, RW0_wmode, RW0_addr);
    end
    n_cmp++;
    if (resp_valid !== 1'b0 || credits_used !== 3'd0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: resp_valid=%b credits=%0d req_ready=%b expected 0/0/0",
               resp_valid, credits_used, req_ready);
    end
    rst = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_preload();
    resp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1;
      req_wmode = 1'b1;
      req_addr  = 12'(i);
      req_wdata = 8'($urandom);
      step();
      n_cmp++;
      if (RW0_en !== 1'b1 || RW0_wmode !== 1'b1 || RW0_addr !== 12'(i) || credits_used !== 3'd0) begin
        n_fail++;
        $display("FAIL preload_write: en=%b wmode=%b addr=%03h credits=%0d expected 1/1/%03h/0",
                 RW0_en, RW0_wmode, RW0_addr, credits_used, 12'(i));
      end
    end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_raw();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_wmode  = 1'b1;
    req_addr   = 12'h123;
    req_wdata  = 8'hA5;
    #1;
    n_cmp++;
    if (RW0_wdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL raw_wdata_pass: got %02h expected a5", RW0_wdata);
    end
    step();
    req_wmode = 1'b0;
    req_wdata = 8'h00;
    step();
    req_valid = 1'b0;
    n_cmp++;
    if (RW0_en !== 1'b1 || RW0_wmode !== 1'b0 || RW0_addr !== 12'h123) begin
      n_fail++;
      $display("FAIL raw_read_issue: en=%b wmode=%b addr=%03h expected 1/0/123", RW0_en, RW0_wmode, RW0_addr);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++;
      if (resp_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL raw_latency: edge %0d resp_valid=%b expected %b", i, resp_valid, (i == 3));
      end
    end
    n_cmp++;
    if (resp_rdata !== 8'hA5 || credits_used !== 3'd1) begin
      n_fail++;
      $display("FAIL raw_data: rdata=%02h credits=%0d expected a5/1", resp_rdata, credits_used);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || credits_used !== 3'd0) begin
      n_fail++;
      $display("FAIL raw_pop: resp_valid=%b credits=%0d expected 0/0", resp_valid, credits_used);
    end
  endtask

  task automatic test_credits();
    int accepted = 0;
    resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_wmode = 1'b0;
      req_addr  = 12'(i);
      #1;
      if (req_ready) accepted++;
      step();
    end
    req_valid = 1'b0;
    n_cmp++;
    if (accepted != 4) begin
      n_fail++;
      $display("FAIL credits_accepted: got %0d expected 4", accepted);
    end
    repeat (3) step();
    n_cmp++;
    if (req_ready !== 1'b0 || credits_used !== 3'd4 || resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL credits_full: req_ready=%b credits=%0d resp_valid=%b expected 0/4/1",
               req_ready, credits_used, resp_valid);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || credits_used !== 3'd3) begin
      n_fail++;
      $display("FAIL credits_release: req_ready=%b credits=%0d expected 1/3", req_ready, credits_used);
    end
    drain_responses("credits");
  endtask

  task automatic test_interleave();
    logic [7:0] got [$];
    int  en_run  = 0;
    int  first_v = 0;
    int  ec      = 0;
    bit  en_low  = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_wmode = (i % 2 == 0);
      req_addr  = 12'h001;
      req_wdata = (i == 0) ? 8'h11 : 8'h22;
      step();
      ec++;
      if (RW0_en === 1'b1) en_run++;
      if (resp_valid && first_v == 0) first_v = ec;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (resp_valid && resp_ready) got.push_back(resp_rdata);
      step();
      ec++;
      if (i == 0) en_low = (RW0_en === 1'b0);
      if (resp_valid && first_v == 0) first_v = ec;
    end
    resp_ready = 1'b0;
    n_cmp++;
    if (en_run != 4 || !en_low) begin
      n_fail++;
      $display("FAIL interleave_en: high=%0d low_after=%b expected 4/1", en_run, en_low);
    end
    n_cmp++;
    if (first_v != 5) begin
      n_fail++;
      $display("FAIL interleave_latency: first resp_valid after edge %0d expected 5", first_v);
    end
    n_cmp++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL interleave_count: got %0d responses expected 2", got.size());
    end else if (got[0] !== 8'h11 || got[1] !== 8'h22) begin
      n_fail++;
      $display("FAIL interleave_order: got %02h,%02h expected 11,22", got[0], got[1]);
    end
  endtask

  task automatic test_flow();
    int nxt  = 4;
    int npop = 0;
    resp_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      req_valid = 1'b1;
      req_wmode = 1'b1;
      req_addr  = 12'(32 + i);
      req_wdata = 8'(64 + i);
      step();
    end
    req_wmode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr = 12'(32 + i);
      step();
    end
    req_valid = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (credits_used !== 3'd4 || resp_valid !== 1'b1 || resp_rdata !== 8'h40) begin
      n_fail++;
      $display("FAIL flow_full: credits=%0d resp_valid=%b rdata=%02h expected 4/1/40",
               credits_used, resp_valid, resp_rdata);
    end
    for (int c = 0; c < 20; c++) begin
      resp_ready = 1'b1;
      req_valid  = (nxt < 12);
      req_wmode  = 1'b0;
      req_addr   = 12'(32 + nxt);
      #1;
      if (resp_valid) begin
        n_cmp++;
        if (resp_rdata !== 8'(64 + npop)) begin
          n_fail++;
          $display("FAIL flow_order: pop %0d got %02h expected %02h", npop, resp_rdata, 8'(64 + npop));
        end
        npop++;
      end
      n_cmp++;
      if (int'(credits_used) !== exp_q.size()) begin
        n_fail++;
        $display("FAIL flow_credits: got %0d expected %0d", credits_used, exp_q.size());
      end
      if (req_valid && req_ready) nxt++;
      step();
    end
    drain_responses("flow");
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    resp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1;
      req_wmode = 1'b0;
      req_addr  = 12'(32 + i);
      step();
    end
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_ready: got %b expected 0", req_ready);
    end
    step();
    rst = 1'b0;
    exp_q.delete();
    n_cmp++;
    if (credits_used !== 3'd0 || RW0_en !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: credits=%0d en=%b resp_valid=%b expected 0/0/0",
               credits_used, RW0_en, resp_valid);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (resp_valid) seen++;
    end
    n_cmp++;
    if (seen != 0 || credits_used !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_discard: valid cycles=%0d credits=%0d expected 0/0", seen, credits_used);
    end
  endtask

  task automatic test_random();
    int done = 0;
    int cyc  = 0;
    while (done < 1000 && cyc < 20000) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_wmode  = 1'($urandom_range(0, 1));
      req_addr   = 12'($urandom_range(0, 15));
      req_wdata  = 8'($urandom);
      resp_ready = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (req_ready !== (exp_q.size() < RESP_DEPTH)) begin
        n_fail++;
        $display("FAIL rand_ready: cycle %0d got %b with %0d pending", cyc, req_ready, exp_q.size());
      end
      n_cmp++;
      if (int'(credits_used) !== exp_q.size()) begin
        n_fail++;
        $display("FAIL rand_credits: cycle %0d got %0d expected %0d", cyc, credits_used, exp_q.size());
      end
      if (resp_valid && resp_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: cycle %0d unexpected response %02h", cyc, resp_rdata);
        end else if (resp_rdata !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rand_data: cycle %0d got %02h expected %02h", cyc, resp_rdata, exp_q[0]);
        end
      end
      if (req_valid && req_ready) done++;
      step();
      cyc++;
    end
    n_cmp++;
    if (done != 1000) begin
      n_fail++;
      $display("FAIL rand_budget: accepted %0d expected 1000", done);
    end
    drain_responses("rand");
  endtask

  initial begin
    test_reset();
    test_preload();
    test_raw();
    test_credits();
    test_interleave();
    test_flow();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
